// File: rtl/mv_select.sv
// Minimum-SAD tracker for a block-matching search window; aligns the PE SAD stream
// with the delayed controller schedule and hands the winning vector to a 1-entry buffer.
module mv_select #(
  parameter int SAD_WIDTH   = 16,
  parameter int PE_LAT      = 2,
  parameter int SEARCH_ROWS = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_init,
  input  logic                 en_pe,
  input  logic [3:0]           ctr_word,
  input  logic [SAD_WIDTH-1:0] sad_in,
  output logic [3:0]           mv_x,
  output logic [3:0]           mv_y,
  output logic [SAD_WIDTH-1:0] sad_min,
  output logic                 mv_valid,
  input  logic                 mv_ready,
  output logic                 overflow
);

  localparam int RW = (SEARCH_ROWS > 1) ? $clog2(SEARCH_ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(SEARCH_ROWS - 1);

  function automatic logic [3:0] mv_offset(input logic [4:0] pos, input logic [4:0] centre);
    logic signed [4:0] diff;
    diff = $signed(pos - centre);
    return diff[3:0];
  endfunction

  logic                 en_p0  [PE_LAT];
  logic [3:0]           col_p0 [PE_LAT];
  logic                 d_en;
  logic [3:0]           d_col;

  logic [SAD_WIDTH-1:0] best_sad_p1;
  logic [3:0]           best_col_p1;
  logic [RW-1:0]        best_row_p1;
  logic [RW-1:0]        row_cnt_p1;
  logic                 first_p1;
  logic                 seen_p1;
  logic                 d_en_q_p1;

  logic                 vld_p2;
  logic [3:0]           res_x_p2;
  logic [3:0]           res_y_p2;
  logic [SAD_WIDTH-1:0] res_sad_p2;

  logic                 accept;
  logic                 take;
  logic                 burst_end;

  // Stage p0: schedule delay line, PE_LAT deep, so d_en/d_col line up with sad_in
  always_ff @(posedge clk) begin
    if (!rst_n || en_init) begin
      for (int i = 0; i < PE_LAT; i++) begin
        en_p0[i]  <= 1'b0;
        col_p0[i] <= '0;
      end
    end else begin
      en_p0[0]  <= en_pe;
      col_p0[0] <= ctr_word;
      for (int i = 1; i < PE_LAT; i++) begin
        en_p0[i]  <= en_p0[i-1];
        col_p0[i] <= col_p0[i-1];
      end
    end
  end

  assign d_en  = en_p0[PE_LAT-1];
  assign d_col = col_p0[PE_LAT-1];

  always_comb begin
    accept    = d_en && (d_col != 4'd0);
    take      = accept && (first_p1 || (sad_in < best_sad_p1));
    burst_end = d_en_q_p1 && !d_en && seen_p1;
  end

  // Stage p1: running minimum over the window; strict compare keeps the earliest tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_sad_p1 <= '0;
      best_col_p1 <= '0;
      best_row_p1 <= '0;
      row_cnt_p1  <= '0;
      first_p1    <= 1'b1;
      seen_p1     <= 1'b0;
      d_en_q_p1   <= 1'b0;
      vld_p2      <= 1'b0;
      res_x_p2    <= '0;
      res_y_p2    <= '0;
      res_sad_p2  <= '0;
    end else begin
      vld_p2 <= 1'b0;
      if (en_init) begin
        best_sad_p1 <= '0;
        best_col_p1 <= '0;
        best_row_p1 <= '0;
        row_cnt_p1  <= '0;
        first_p1    <= 1'b1;
        seen_p1     <= 1'b0;
        d_en_q_p1   <= 1'b0;
      end else begin
        d_en_q_p1 <= d_en;
        if (take) begin
          best_sad_p1 <= sad_in;
          best_col_p1 <= d_col;
          best_row_p1 <= row_cnt_p1;
        end
        if (accept) begin
          first_p1 <= 1'b0;
          seen_p1  <= 1'b1;
        end
        if (burst_end) begin
          seen_p1 <= 1'b0;
          if (row_cnt_p1 != LAST_ROW) begin
            row_cnt_p1 <= row_cnt_p1 + 1'b1;
          end else begin
            vld_p2     <= 1'b1;
            res_x_p2   <= mv_offset({1'b0, best_col_p1}, 5'd8);
            res_y_p2   <= mv_offset(5'(best_row_p1), 5'd7);
            res_sad_p2 <= best_sad_p1;
            first_p1   <= 1'b1;
            row_cnt_p1 <= '0;
          end
        end
      end
    end
  end

  // Stage p2: one-entry result buffer; a commit into a full, stalled buffer is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mv_x     <= '0;
      mv_y     <= '0;
      sad_min  <= '0;
      mv_valid <= 1'b0;
      overflow <= 1'b0;
    end else if (vld_p2) begin
      if (!mv_valid || mv_ready) begin
        mv_x     <= res_x_p2;
        mv_y     <= res_y_p2;
        sad_min  <= res_sad_p2;
        mv_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (mv_valid && mv_ready) begin
      mv_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mv_select.sv
// Directed and randomized bench for mv_select; expected vectors come from a raster-scan
// minimum search over the SAD table driven into the design.
module tb_mv_select;

  localparam int PE_LAT = 2;
  localparam int ROWS   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_init = 1'b0;
  logic        en_pe = 1'b0;
  logic [3:0]  ctr_word = '0;
  logic [15:0] sad_in = '0;
  logic [3:0]  mv_x;
  logic [3:0]  mv_y;
  logic [15:0] sad_min;
  logic        mv_valid;
  logic        mv_ready = 1'b0;
  logic        overflow;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] tbl [ROWS][16];
  logic [15:0] sad_pipe [PE_LAT];

  mv_select #(.SAD_WIDTH(16), .PE_LAT(PE_LAT), .SEARCH_ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .en_init(en_init), .en_pe(en_pe), .ctr_word(ctr_word),
    .sad_in(sad_in), .mv_x(mv_x), .mv_y(mv_y), .sad_min(sad_min), .mv_valid(mv_valid),
    .mv_ready(mv_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One controller cycle: drive schedule now, deliver the SAD PE_LAT cycles later
  task automatic cyc(input logic en, input logic [3:0] col, input logic [15:0] sad);
    @(negedge clk);
    en_pe    = en;
    ctr_word = col;
    sad_in   = sad_pipe[PE_LAT-1];
    for (int i = PE_LAT-1; i > 0; i--) sad_pipe[i] = sad_pipe[i-1];
    sad_pipe[0] = sad;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 16'd0);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 16; c++) tbl[r][c] = v;
  endtask

  task automatic fill_rand(input int hi);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 16; c++) tbl[r][c] = 16'($urandom_range(0, hi));
  endtask

  task automatic model(output logic [3:0] ex, output logic [3:0] ey, output logic [15:0] es);
    int br, bc;
    br = -1; bc = 0; es = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 1; c <= 15; c++)
        if (br < 0 || tbl[r][c] < es) begin
          br = r; bc = c; es = tbl[r][c];
        end
    ex = 4'(bc - 8);
    ey = 4'(br - 7);
  endtask

  task automatic run_rows(input int nrows, input int gap, input bit ins_zero);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 1; c <= 15; c++) begin
        if (ins_zero && c == 8) cyc(1'b1, 4'd0, 16'd0);
        cyc(1'b1, 4'(c), tbl[r][c]);
      end
      if (r < nrows - 1) idle(gap);
    end
  endtask

  task automatic run_search(input string tag, input int gap, input bit ins_zero, input bit chk_lat);
    run_rows(ROWS, gap, ins_zero);
    cyc(1'b0, 4'd0, 16'd0);
    idle(PE_LAT + 1);
    if (chk_lat) chk({tag, "_valid_early"}, 32'(mv_valid), 32'd0);
    idle(1);
    if (chk_lat) chk({tag, "_valid_rise"}, 32'(mv_valid), 32'd1);
  endtask

  task automatic check_result(input string tag);
    logic [3:0] ex, ey;
    logic [15:0] es;
    model(ex, ey, es);
    chk({tag, "_mv_x"}, 32'(mv_x), 32'(ex));
    chk({tag, "_mv_y"}, 32'(mv_y), 32'(ey));
    chk({tag, "_sad"}, 32'(sad_min), 32'(es));
  endtask

  task automatic consume(input string tag);
    mv_ready = 1'b1;
    cyc(1'b0, 4'd0, 16'd0);
    mv_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(mv_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] hx, hy;
    logic [15:0] hs;
    for (int i = 0; i < PE_LAT; i++) sad_pipe[i] = '0;

    // Reset state
    idle(3);
    chk("rst_mv_x", 32'(mv_x), 32'd0);
    chk("rst_mv_y", 32'(mv_y), 32'd0);
    chk("rst_sad", 32'(sad_min), 32'd0);
    chk("rst_valid", 32'(mv_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single minimum at row 3 / column 12
    fill(16'd1000);
    tbl[3][12] = 16'd50;
    run_search("single", 1, 1'b0, 1'b1);
    check_result("single");
    chk("single_x_const", 32'(mv_x), 32'h4);
    chk("single_y_const", 32'(mv_y), 32'hC);
    chk("single_sad_const", 32'(sad_min), 32'd50);
    consume("single");

    // Tie-break keeps the earliest candidate
    fill(16'd9);
    tbl[0][1] = 16'd0;
    tbl[14][15] = 16'd0;
    run_search("tie", 2, 1'b0, 1'b1);
    check_result("tie");
    chk("tie_x_const", 32'(mv_x), 32'h9);
    consume("tie");

    // All-maximum SAD
    fill(16'hFFFF);
    run_search("allmax", 1, 1'b0, 1'b1);
    check_result("allmax");
    consume("allmax");

    // Ignored ctr_word=0 cycles and 5-cycle gaps
    fill(16'd100);
    tbl[9][4] = 16'd7;
    run_search("ignore", 5, 1'b1, 1'b1);
    check_result("ignore");
    consume("ignore");

    // Backpressure: second result dropped, first held
    fill_rand(200);
    run_search("bp1", 1, 1'b0, 1'b1);
    check_result("bp1");
    model(hx, hy, hs);
    chk("bp1_ovf", 32'(overflow), 32'd0);
    fill(16'd3);
    tbl[5][5] = 16'd1;
    run_search("bp2", 2, 1'b0, 1'b0);
    chk("bp2_valid_held", 32'(mv_valid), 32'd1);
    chk("bp2_ovf", 32'(overflow), 32'd1);
    chk("bp2_x_held", 32'(mv_x), 32'(hx));
    chk("bp2_y_held", 32'(mv_y), 32'(hy));
    chk("bp2_sad_held", 32'(sad_min), 32'(hs));
    consume("bp2");
    chk("bp2_ovf_sticky", 32'(overflow), 32'd1);

    // Abort after row 7, then a full search
    fill(16'd1);
    run_rows(8, 2, 1'b0);
    idle(2);
    en_init = 1'b1;
    cyc(1'b0, 4'd0, 16'd0);
    en_init = 1'b0;
    idle(1);
    fill(16'd500);
    tbl[7][8] = 16'd20;
    run_search("abort", 1, 1'b0, 1'b1);
    check_result("abort");
    chk("abort_x_const", 32'(mv_x), 32'd0);
    chk("abort_y_const", 32'(mv_y), 32'd0);

    // Reset during a burst with a result still held
    for (int c = 1; c <= 5; c++) cyc(1'b1, 4'(c), 16'd1);
    rst_n = 1'b0;
    cyc(1'b1, 4'd6, 16'd1);
    chk("midrst_mv_x", 32'(mv_x), 32'd0);
    chk("midrst_mv_y", 32'(mv_y), 32'd0);
    chk("midrst_sad", 32'(sad_min), 32'd0);
    chk("midrst_valid", 32'(mv_valid), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 4'd0, 16'd0);
    for (int i = 0; i < PE_LAT; i++) sad_pipe[i] = '0;
    rst_n = 1'b1;
    idle(2);

    // Randomized searches
    for (int k = 0; k < 4; k++) begin
      fill_rand(k < 2 ? 15 : 60000);
      run_search($sformatf("rand%0d", k), int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 1'b1);
      check_result($sformatf("rand%0d", k));
      consume($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
